// File: rtl/mem2axi.sv
// mem2axi: single-outstanding AXI4-Lite initiator for a simple load/store request port.
// Optional MEM2AXI_ALIGN_CHECK_EN: misaligned requests get an error response and never reach the bus.
module mem2axi #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [1:0]          req_size,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WREQ  = 3'd3,
      WRESP = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   logic aw_done;
   logic w_done;
   logic accept;
   logic misaligned;
   logic go_bus;
   logic ar_hs;
   logic r_hs;
   logic aw_hs;
   logic w_hs;
   logic b_hs;
   logic aw_fin;
   logic w_fin;

   assign accept = req_valid & req_ready;
   assign go_bus = accept & ~misaligned;
   assign ar_hs  = arvalid & arready;
   assign r_hs   = rvalid & rready;
   assign aw_hs  = awvalid & awready;
   assign w_hs   = wvalid & wready;
   assign b_hs   = bvalid & bready;
   assign aw_fin = aw_done | aw_hs;
   assign w_fin  = w_done | w_hs;

`ifdef MEM2AXI_ALIGN_CHECK_EN
   assign misaligned = ((req_size == 2'd1) & req_addr[0])
                     | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00))
                     |  (req_size == 2'd3);
`else
   logic unused_size;
   assign unused_size = ^req_size;
   assign misaligned  = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go_bus) state_nxt = req_wen ? WREQ : RADDR;
         RADDR:   if (ar_hs) state_nxt = RDATA;
         RDATA:   if (r_hs) state_nxt = IDLE;
         WREQ:    if (aw_fin && w_fin) state_nxt = WRESP;
         WRESP:   if (b_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // handshake decode, driven only from flops so no valid can follow a ready
   always_comb begin
      req_ready = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      case (state)
         IDLE:    req_ready = 1'b1;
         RADDR:   arvalid   = 1'b1;
         RDATA:   rready    = 1'b1;
         WREQ: begin
            awvalid = ~aw_done;
            wvalid  = ~w_done;
         end
         WRESP:   bready    = 1'b1;
         default: ;
      endcase
   end

   // AW and W retire independently; flags only live while in WREQ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (state != WREQ) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
      end
   end

   // bus payload, frozen from accept until the next accepted request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         araddr <= '0;
         awaddr <= '0;
         wdata  <= '0;
         wstrb  <= STRB_W'(0);
      end else if (go_bus) begin
         if (req_wen) begin
            awaddr <= req_addr;
            wdata  <= req_wdata;
            wstrb  <= req_wstrb;
         end else begin
            araddr <= req_addr;
         end
      end
   end

   // one-cycle response pulse after the final R/B beat or a rejected request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         if (r_hs) begin
            resp_valid <= 1'b1;
            resp_err   <= (rresp != 2'b00);
            resp_rdata <= (rresp == 2'b00) ? rdata : '0;
         end else if (b_hs) begin
            resp_valid <= 1'b1;
            resp_err   <= (bresp != 2'b00);
            resp_rdata <= '0;
         end else if (accept && misaligned) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem2axi.sv
// tb_mem2axi: randomized bench for mem2axi with an in-bench AXI-Lite slave and a response scoreboard.
module tb_mem2axi;

`ifdef MEM2AXI_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk, rst;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
   logic [1:0]  rresp, bresp;
   logic [3:0]  wstrb;

   int   errors, checks;
   exp_t exp_q[$];
   logic [31:0] model_mem [16];
   logic [31:0] slave_mem [16];

   mem2axi #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
      .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && resp_valid) begin
         check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("resp", 64'({resp_err, resp_rdata}), 64'(e));
         end
      end
   end

   // issue one request and play the slave side; lat = negedges from accept to resp_valid
   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input logic [3:0] ws, input logic [1:0] code,
                          input int a_wait, input int w_wait, input int d_wait, output int lat);
      exp_t e;
      int   idx, n, acnt, wcnt, dcnt;
      logic mis;
      bit   a_hs, a_dn, w_hs, w_dn, fin;
      logic [31:0] cap_a, cap_wd;
      logic [3:0]  cap_ws;
      idx = int'(addr[5:2]);
      mis = ALIGN_EN && ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00) || size == 2'd3);
      if (mis) e = '{err: 1'b1, rdata: 32'h0};
      else if (wr) begin
         e = '{err: (code != 2'b00), rdata: 32'h0};
         if (code == 2'b00)
            for (int b = 0; b < 4; b++) if (ws[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else e = '{err: (code != 2'b00), rdata: (code == 2'b00) ? model_mem[idx] : 32'h0};
      exp_q.push_back(e);
      check("req_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_wen = wr; req_addr = addr; req_size = size; req_wdata = wd; req_wstrb = ws;
      @(posedge clk);
      lat = -1; n = 1; acnt = 0; wcnt = 0; dcnt = 0;
      a_hs = 0; a_dn = 0; w_hs = 0; w_dn = 0; fin = 0; cap_a = '0; cap_wd = '0; cap_ws = '0;
      while (lat < 0 && n <= 100) begin
         @(negedge clk);
         if (n == 1) begin
            req_valid = 1'b0; req_addr = $urandom; req_wen = 1'($urandom);
            req_wdata = $urandom; req_wstrb = 4'($urandom); req_size = 2'($urandom);
         end
         if (fin || mis) begin
            check("resp_timing", 64'(resp_valid), 64'd1);
            check("bus_quiet", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
            rvalid = 1'b0; bvalid = 1'b0; lat = n;
         end else if (!wr) begin
            if (a_hs) begin a_dn = 1; a_hs = 0; arready = 1'b0; end
            if (!a_dn) begin
               check("arvalid_hold", 64'(arvalid), 64'd1);
               check("araddr", 64'(araddr), 64'(addr));
               check("rready_early", 64'(rready), 64'd0);
               rvalid = 1'($urandom); rdata = 32'hBAD0_0BAD; rresp = 2'b00;
               if (acnt >= a_wait) begin arready = 1'b1; a_hs = 1; cap_a = araddr; end
               else acnt++;
            end else begin
               check("arvalid_drop", 64'(arvalid), 64'd0);
               check("rready", 64'(rready), 64'd1);
               if (dcnt >= d_wait) begin
                  rvalid = 1'b1; rresp = code; fin = 1;
                  rdata  = (code == 2'b00) ? slave_mem[int'(cap_a[5:2])] : $urandom;
               end else begin rvalid = 1'b0; dcnt++; end
            end
         end else begin
            if (a_hs) begin a_dn = 1; a_hs = 0; awready = 1'b0; end
            if (w_hs) begin w_dn = 1; w_hs = 0; wready = 1'b0; end
            if (!(a_dn && w_dn)) begin
               check("bready_early", 64'(bready), 64'd0);
               bvalid = 1'($urandom); bresp = 2'b00;
               if (!a_dn) begin
                  check("awvalid_hold", 64'(awvalid), 64'd1);
                  check("awaddr", 64'(awaddr), 64'(addr));
                  if (acnt >= a_wait) begin awready = 1'b1; a_hs = 1; cap_a = awaddr; end
                  else acnt++;
               end else check("awvalid_drop", 64'(awvalid), 64'd0);
               if (!w_dn) begin
                  check("wvalid_hold", 64'(wvalid), 64'd1);
                  check("wdata_wstrb", 64'({wdata, wstrb}), 64'({wd, ws}));
                  if (wcnt >= w_wait) begin wready = 1'b1; w_hs = 1; cap_wd = wdata; cap_ws = wstrb; end
                  else wcnt++;
               end else check("wvalid_drop", 64'(wvalid), 64'd0);
            end else begin
               check("bready", 64'(bready), 64'd1);
               check("aw_w_idle", 64'({awvalid, wvalid}), 64'd0);
               if (dcnt >= d_wait) begin
                  bvalid = 1'b1; bresp = code; fin = 1;
                  if (code == 2'b00)
                     for (int b = 0; b < 4; b++)
                        if (cap_ws[b]) slave_mem[int'(cap_a[5:2])][8*b +: 8] = cap_wd[8*b +: 8];
               end else begin bvalid = 1'b0; dcnt++; end
            end
         end
         n++;
      end
      check("txn_done", 64'(lat > 0), 64'd1);
      arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int lat;
      logic [1:0] code;
      errors = 0; checks = 0;
      rst = 1'b1;
      req_valid = 0; req_wen = 0; req_addr = '0; req_size = '0; req_wdata = '0; req_wstrb = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0;
      awready = 0; wready = 0; bvalid = 0; bresp = '0;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = $urandom;
         slave_mem[i] = model_mem[i];
      end
      model_mem[1] = 32'hDEAD_BEEF; slave_mem[1] = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      check("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready, resp_valid}), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_resp", 64'({resp_err, resp_rdata}), 64'd0);
      check("rst_addr", 64'({araddr, awaddr}), 64'd0);
      check("rst_wdata", 64'({wdata, wstrb}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_txn(1'b0, 32'h8000_0004, 2'd2, 32'h0, 4'h0, 2'b00, 0, 0, 0, lat);
      check("rd_latency", 64'(lat), 64'd3);
      run_txn(1'b1, 32'h8000_0010, 2'd2, 32'h1234_5678, 4'hF, 2'b00, 2, 0, 0, lat);
      run_txn(1'b0, 32'h8000_0010, 2'd2, 32'h0, 4'h0, 2'b00, 0, 0, 0, lat);
      run_txn(1'b0, 32'h8000_0008, 2'd2, 32'h0, 4'h0, 2'b10, 5, 0, 1, lat);
      run_txn(1'b1, 32'h8000_0014, 2'd2, 32'hCAFE_F00D, 4'h5, 2'b00, 0, 0, 0, lat);
      check("wr_latency", 64'(lat), 64'd3);
      run_txn(1'b0, 32'h8000_0014, 2'd2, 32'h0, 4'h0, 2'b00, 0, 0, 0, lat);

      // reset while AW and W are both pending
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_size = 2'd2;
      req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("pre_rst_valid", 64'({awvalid, wvalid}), 64'd3);
      rst = 1'b1;
      #1;
      check("rst_async", 64'({awvalid, wvalid, bready}), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_ready", 64'(req_ready), 64'd1);
      check("rst_no_resp", 64'(resp_valid), 64'd0);
      run_txn(1'b0, 32'h8000_0020, 2'd2, 32'h0, 4'h0, 2'b00, 0, 0, 0, lat);

      run_txn(1'b0, 32'h8000_0002, 2'd2, 32'h0, 4'h0, 2'b00, 0, 0, 0, lat);
      check("mis_latency", 64'(lat), ALIGN_EN ? 64'd1 : 64'd3);

      for (int t = 0; t < 300; t++) begin
         code = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_txn(1'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 63)), 2'($urandom),
                 $urandom, 4'($urandom_range(1, 15)), code,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), lat);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      check("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
